// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: pipeline-wide defines shared by EX_MEM and mem_stage
// (opcodes, funct3 codes, stall masks, byte-count helper).
package mem_stage_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] ZeroWord = '0;

    localparam logic [5:0] STALL_MASK_NONE = 6'b000000;
    localparam logic [5:0] STALL_MASK_MEM  = 6'b001111;

    // Index of the final byte of an access; undefined sizes behave as a word.
    function automatic logic [1:0] last_byte(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// mem_stage_load_extend: sign/zero extension of assembled load data to 32 bits.
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    output logic [31:0] rd_val
);

    always_comb begin
        case (funct3)
            F3_B:    rd_val = {{24{data[7]}}, data[7:0]};
            F3_H:    rd_val = {{16{data[15]}}, data[15:0]};
            F3_BU:   rd_val = {24'b0, data[7:0]};
            F3_HU:   rd_val = {16'b0, data[15:0]};
            F3_W:    rd_val = data;
            default: rd_val = data;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage running RV32I loads/stores as byte-serial transfers.
// Optional MEM_ALIGN_TRAP_EN: misaligned H/W accesses trap via misalign_err instead of executing.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        forward,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_val,
    input  logic [6:0]  ins_type,
    input  logic [2:0]  ins_details,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_val,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_wdata,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_rdata,
    output logic        stall_req,
    output logic        output_forward,
    output logic [4:0]  output_rd_addr,
    output logic [31:0] output_rd_val
`ifdef MEM_ALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    typedef enum logic [1:0] { IDLE, ACCESS, FINISH, DONE } state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt;
    logic [1:0]  cnt_prev;
    logic        pend;
    logic [31:0] data;
    logic        is_load, is_store, is_mem, last_gnt, misaligned;
    logic [31:0] ext_val;

    assign is_load  = (ins_type == OPC_LOAD);
    assign is_store = (ins_type == OPC_STORE);
    assign is_mem   = is_load | is_store;
    assign cnt_prev = cnt - 2'd1;
    assign last_gnt = mem_gnt && (cnt == last_byte(ins_details));

`ifdef MEM_ALIGN_TRAP_EN
    assign misaligned = ((ins_details[1:0] == 2'b01) && mem_addr[0]) ||
                        (ins_details[1] && (mem_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    mem_stage_load_extend u_load_extend (
        .data   (data),
        .funct3 (ins_details),
        .rd_val (ext_val)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (is_mem) state_nxt = misaligned ? DONE : ACCESS;
            ACCESS:  if (last_gnt) state_nxt = is_load ? FINISH : DONE;
            FINISH:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // All outputs are decoded from state; reset overrides them in the same cycle.
    always_comb begin
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_a          = ZeroWord;
        mem_wdata      = '0;
        stall_req      = 1'b0;
        output_forward = 1'b0;
        output_rd_addr = '0;
        output_rd_val  = ZeroWord;
`ifdef MEM_ALIGN_TRAP_EN
        misalign_err   = 1'b0;
`endif
        if (!rst_in) begin
            case (state)
                IDLE: begin
                    output_rd_addr = rd_addr;
                    if (is_mem) begin
                        stall_req = 1'b1;
                    end else begin
                        output_forward = forward;
                        output_rd_val  = rd_val;
                    end
                end
                ACCESS: begin
                    stall_req = 1'b1;
                    mem_req   = rdy_in;
                    mem_we    = is_store;
                    mem_a     = mem_addr + {30'b0, cnt};
                    mem_wdata = mem_val[{cnt, 3'b000} +: 8];
                end
                FINISH: stall_req = 1'b1;
                DONE: begin
                    output_rd_addr = rd_addr;
                    if (is_load && !misaligned) begin
                        output_forward = 1'b1;
                        output_rd_val  = ext_val;
                    end
`ifdef MEM_ALIGN_TRAP_EN
                    misalign_err = misaligned;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
            data  <= ZeroWord;
        end else if (rdy_in) begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    pend <= 1'b0;
                end
                // Read data lags its grant by one cycle, so it lands in byte cnt-1.
                ACCESS: begin
                    if (pend) data[{cnt_prev, 3'b000} +: 8] <= mem_rdata;
                    if (mem_gnt) cnt <= cnt + 2'd1;
                    pend <= mem_gnt && is_load;
                end
                FINISH: begin
                    if (pend) data[{cnt_prev, 3'b000} +: 8] <= mem_rdata;
                    pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage with a byte-addressed
// memory responder and a reference memory/latency model.
`timescale 1ns/1ps
module tb_mem_stage;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ALU   = 7'b0010011;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, forward, mem_gnt;
    logic [4:0]  rd_addr;
    logic [31:0] rd_val, mem_addr, mem_val;
    logic [6:0]  ins_type;
    logic [2:0]  ins_details;
    logic [7:0]  mem_rdata;
    logic        mem_req, mem_we, stall_req, output_forward;
    logic [31:0] mem_a, output_rd_val;
    logic [7:0]  mem_wdata;
    logic [4:0]  output_rd_addr;
`ifdef MEM_ALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct { logic we; logic [31:0] a; logic [7:0] d; } xfer_t;
    xfer_t      log_q[$];
    logic [7:0] dmem    [bit [31:0]];
    logic [7:0] ref_mem [bit [31:0]];

    mem_stage dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .forward        (forward),
        .rd_addr        (rd_addr),
        .rd_val         (rd_val),
        .ins_type       (ins_type),
        .ins_details    (ins_details),
        .mem_addr       (mem_addr),
        .mem_val        (mem_val),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_a          (mem_a),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rdata      (mem_rdata),
        .stall_req      (stall_req),
        .output_forward (output_forward),
        .output_rd_addr (output_rd_addr),
        .output_rd_val  (output_rd_val)
`ifdef MEM_ALIGN_TRAP_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Memory controller: read byte valid the cycle after its grant; frozen with rdy_in.
    always @(posedge clk_in) begin
        xfer_t x;
        if (rdy_in) begin
            if (mem_req && mem_gnt) begin
                x.we = mem_we; x.a = mem_a; x.d = mem_wdata;
                log_q.push_back(x);
                if (mem_we) dmem[mem_a] = mem_wdata;
                mem_rdata <= dmem.exists(mem_a) ? dmem[mem_a] : 8'h00;
            end else begin
                mem_rdata <= 8'($urandom);
            end
        end
    end

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        dmem[a]    = b;
        ref_mem[a] = b;
    endtask

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        longint v = 0;
        int n = nbytes(f3);
        for (int i = 0; i < n; i++) v += longint'(ref_rd(a + 32'(i))) << (8 * i);
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic logic ref_misaligned(input logic [31:0] a, input logic [2:0] f3);
`ifdef MEM_ALIGN_TRAP_EN
        int n = nbytes(f3);
        return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
        return (a[0] & f3[0]) & 1'b0;
`endif
    endfunction

    // Runs one instruction to completion; starts and ends just after a rising edge.
    task automatic drive_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] val, input logic [31:0] wbv, input logic [4:0] rd,
                            input logic fwd_in, input int gap, input int rdy_at, input int rdy_len,
                            output int stalls, output logic fwd, output logic [31:0] rv,
                            output logic [4:0] ra, output int merr, output logic tout);
        int gcnt = 0;
        ins_type = op; ins_details = f3; mem_addr = addr; mem_val = val;
        rd_val = wbv; rd_addr = rd; forward = fwd_in;
        log_q.delete();
        stalls = 0; merr = 0; tout = 1'b1; fwd = 1'b0; rv = '0; ra = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            rdy_in  = !(cyc >= rdy_at && cyc < rdy_at + rdy_len);
            mem_gnt = (gcnt >= gap);
            #1;
`ifdef MEM_ALIGN_TRAP_EN
            if (misalign_err) merr++;
`endif
            if (stall_req) stalls++;
            if (!stall_req && rdy_in) begin
                fwd = output_forward; rv = output_rd_val; ra = output_rd_addr; tout = 1'b0;
            end
            if (mem_req) gcnt = mem_gnt ? 0 : gcnt + 1;
            @(posedge clk_in); #1;
            if (!tout) break;
        end
        ins_type = ALU; rdy_in = 1'b1; mem_gnt = 1'b1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; mem_gnt = 1'b1; ins_type = LOAD; ins_details = 3'b010;
        forward = 1'b1; rd_addr = 5'd7; rd_val = 32'hDEADBEEF; mem_addr = 32'h10; mem_val = 32'h55;
        repeat (3) @(posedge clk_in);
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall_req); end
        checks++; if (output_forward !== 1'b0) begin errors++; $display("FAIL rst_fwd got %b exp 0", output_forward); end
        checks++; if (output_rd_val !== 32'h0) begin errors++; $display("FAIL rst_rd_val got %h exp 0", output_rd_val); end
        checks++; if (output_rd_addr !== 5'h0) begin errors++; $display("FAIL rst_rd_addr got %h exp 0", output_rd_addr); end
        checks++; if ({mem_we, mem_a, mem_wdata} !== 41'h0) begin errors++; $display("FAIL rst_mem_bus got %h exp 0", {mem_we, mem_a, mem_wdata}); end
        ins_type = ALU;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
    endtask

    task automatic test_passthrough();
        int st, merr; logic f, to; logic [31:0] rv; logic [4:0] ra;
        ins_type = ALU; ins_details = 3'b000; rd_addr = 5'd5; rd_val = 32'h1234; forward = 1'b1;
        #1;
        checks++; if (output_forward !== 1'b1) begin errors++; $display("FAIL addi_fwd got %b exp 1", output_forward); end
        checks++; if (output_rd_val !== 32'h1234) begin errors++; $display("FAIL addi_rd_val got %h exp 1234", output_rd_val); end
        checks++; if (output_rd_addr !== 5'd5) begin errors++; $display("FAIL addi_rd_addr got %0d exp 5", output_rd_addr); end
        checks++; if (stall_req !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL addi_stall_req got %b%b exp 00", stall_req, mem_req); end
        @(posedge clk_in); #1;
        for (int k = 0; k < 6; k++) begin
            logic [6:0] op; logic [31:0] w; logic [4:0] r; logic fi;
            op = 7'($urandom);
            if (op == LOAD || op == STORE) op = ALU;
            w = $urandom; r = 5'($urandom); fi = 1'($urandom);
            drive_op(op, 3'($urandom), $urandom, $urandom, w, r, fi, 0, -1, 0, st, f, rv, ra, merr, to);
            checks++; if (st !== 0 || to) begin errors++; $display("FAIL pass%0d_stall got %0d exp 0", k, st); end
            checks++; if (f !== fi || rv !== w || ra !== r) begin errors++; $display("FAIL pass%0d_out got %b/%h/%0d exp %b/%h/%0d", k, f, rv, ra, fi, w, r); end
        end
    endtask

    task automatic test_lw();
        int st, merr; logic f, to; logic [31:0] rv; logic [4:0] ra;
        preload(32'h100, 8'h78); preload(32'h101, 8'h56); preload(32'h102, 8'h34); preload(32'h103, 8'h12);
        drive_op(LOAD, 3'b010, 32'h100, 32'h0, 32'h0, 5'd9, 1'b1, 0, -1, 0, st, f, rv, ra, merr, to);
        checks++; if (to || st !== 6) begin errors++; $display("FAIL lw_stall got %0d exp 6", st); end
        checks++; if (rv !== 32'h12345678) begin errors++; $display("FAIL lw_rd_val got %h exp 12345678", rv); end
        checks++; if (f !== 1'b1 || ra !== 5'd9) begin errors++; $display("FAIL lw_fwd got %b/%0d exp 1/9", f, ra); end
        checks++; if (log_q.size() !== 4) begin errors++; $display("FAIL lw_xfers got %0d exp 4", log_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_q[i].a !== 32'h100 + 32'(i) || log_q[i].we !== 1'b0) begin
                errors++; $display("FAIL lw_addr%0d got %h/%b exp %h/0", i, log_q[i].a, log_q[i].we, 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_lb_lbu();
        int st, merr; logic f, to; logic [31:0] rv; logic [4:0] ra;
        preload(32'h200, 8'h80);
        drive_op(LOAD, 3'b000, 32'h200, 32'h0, 32'h0, 5'd3, 1'b1, 0, -1, 0, st, f, rv, ra, merr, to);
        checks++; if (to || st !== 3) begin errors++; $display("FAIL lb_stall got %0d exp 3", st); end
        checks++; if (rv !== 32'hFFFFFF80 || f !== 1'b1) begin errors++; $display("FAIL lb_rd_val got %h exp ffffff80", rv); end
        drive_op(LOAD, 3'b100, 32'h200, 32'h0, 32'h0, 5'd3, 1'b1, 0, -1, 0, st, f, rv, ra, merr, to);
        checks++; if (to || st !== 3) begin errors++; $display("FAIL lbu_stall got %0d exp 3", st); end
        checks++; if (rv !== 32'h00000080 || f !== 1'b1) begin errors++; $display("FAIL lbu_rd_val got %h exp 00000080", rv); end
    endtask

    task automatic test_sh_gap();
        int st, merr; logic f, to; logic [31:0] rv; logic [4:0] ra;
        drive_op(STORE, 3'b001, 32'h300, 32'h0000BEEF, 32'h0, 5'd1, 1'b1, 2, -1, 0, st, f, rv, ra, merr, to);
        ref_mem[32'h300] = 8'hEF; ref_mem[32'h301] = 8'hBE;
        checks++; if (to || st !== 7) begin errors++; $display("FAIL sh_stall got %0d exp 7", st); end
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL sh_fwd got %b exp 0", f); end
        checks++; if (log_q.size() !== 2) begin errors++; $display("FAIL sh_xfers got %0d exp 2", log_q.size()); end
        else begin
            checks++; if (log_q[0].a !== 32'h300 || log_q[0].d !== 8'hEF || log_q[0].we !== 1'b1) begin
                errors++; $display("FAIL sh_byte0 got %h@%h exp ef@300", log_q[0].d, log_q[0].a); end
            checks++; if (log_q[1].a !== 32'h301 || log_q[1].d !== 8'hBE || log_q[1].we !== 1'b1) begin
                errors++; $display("FAIL sh_byte1 got %h@%h exp be@301", log_q[1].d, log_q[1].a); end
        end
    endtask

    task automatic test_rdy_pause();
        int st, merr; logic f, to; logic [31:0] rv; logic [4:0] ra;
        drive_op(LOAD, 3'b010, 32'h100, 32'h0, 32'h0, 5'd9, 1'b1, 0, 2, 3, st, f, rv, ra, merr, to);
        checks++; if (to || st !== 9) begin errors++; $display("FAIL rdy_stall got %0d exp 9", st); end
        checks++; if (rv !== 32'h12345678 || f !== 1'b1) begin errors++; $display("FAIL rdy_rd_val got %h exp 12345678", rv); end
        checks++; if (log_q.size() !== 4) begin errors++; $display("FAIL rdy_xfers got %0d exp 4", log_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_q[i].a !== 32'h100 + 32'(i)) begin
                errors++; $display("FAIL rdy_addr%0d got %h exp %h", i, log_q[i].a, 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int st, merr; logic f, to; logic [31:0] rv; logic [4:0] ra;
        log_q.delete();
        ins_type = STORE; ins_details = 3'b010; mem_addr = 32'h400; mem_val = 32'hA1B2C3D4;
        rdy_in = 1'b1; mem_gnt = 1'b1;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre_req got %b exp 1", mem_req); end
        rst_in = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %b exp 0", mem_req); end
        @(posedge clk_in); #1;
        rst_in = 1'b0; ins_type = 7'h00; ins_details = '0; mem_addr = '0; mem_val = '0;
        forward = 1'b0; rd_addr = '0; rd_val = '0;
        #1;
        checks++; if (stall_req !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b%b exp 00", stall_req, mem_req); end
        checks++; if (output_forward !== 1'b0 || output_rd_val !== 32'h0 || output_rd_addr !== 5'h0) begin
            errors++; $display("FAIL rstmid_outs got %b/%h/%h exp 0/0/0", output_forward, output_rd_val, output_rd_addr); end
        ref_mem[32'h400] = 8'hD4;
        checks++; if (log_q.size() !== 1 || dmem[32'h400] !== 8'hD4) begin
            errors++; $display("FAIL rstmid_partial got %0d xfers exp 1", log_q.size()); end
        @(posedge clk_in); #1;
        drive_op(LOAD, 3'b010, 32'h100, 32'h0, 32'h0, 5'd2, 1'b1, 0, -1, 0, st, f, rv, ra, merr, to);
        checks++; if (to || st !== 6 || rv !== 32'h12345678) begin
            errors++; $display("FAIL rstmid_after got %0d/%h exp 6/12345678", st, rv); end
    endtask

    task automatic test_align();
        int st, merr; logic f, to; logic [31:0] rv; logic [4:0] ra;
`ifdef MEM_ALIGN_TRAP_EN
        drive_op(LOAD, 3'b010, 32'h102, 32'h0, 32'h0, 5'd4, 1'b1, 0, -1, 0, st, f, rv, ra, merr, to);
        checks++; if (to || st !== 1) begin errors++; $display("FAIL mis_lw_stall got %0d exp 1", st); end
        checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL mis_lw_req got %0d exp 0", log_q.size()); end
        checks++; if (merr !== 1 || f !== 1'b0) begin errors++; $display("FAIL mis_lw_err got %0d/%b exp 1/0", merr, f); end
        drive_op(STORE, 3'b001, 32'h301, 32'h1111, 32'h0, 5'd4, 1'b1, 0, -1, 0, st, f, rv, ra, merr, to);
        checks++; if (to || st !== 1 || log_q.size() !== 0 || merr !== 1) begin
            errors++; $display("FAIL mis_sh got %0d/%0d/%0d exp 1/0/1", st, log_q.size(), merr); end
`else
        drive_op(LOAD, 3'b010, 32'h101, 32'h0, 32'h0, 5'd4, 1'b1, 0, -1, 0, st, f, rv, ra, merr, to);
        checks++; if (to || st !== 6) begin errors++; $display("FAIL unal_lw_stall got %0d exp 6", st); end
        checks++; if (rv !== ref_load(32'h101, 3'b010) || f !== 1'b1) begin
            errors++; $display("FAIL unal_lw_rd_val got %h exp %h", rv, ref_load(32'h101, 3'b010)); end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 48; i++) preload(32'hFFFFFFF0 + 32'(i), 8'($urandom));
        for (int i = 0; i < 216; i++) preload(32'h1000 + 32'(i), 8'($urandom));
        for (int k = 0; k < 30; k++) begin
            logic ld, mis, f, to; logic [2:0] f3; logic [31:0] a, v, exp_rv, rv; logic [4:0] rd, ra;
            int n, gap, r_at, r_len, exp_st, st, merr;
            ld  = 1'($urandom_range(0, 1));
            f3  = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
            a   = $urandom_range(0, 1) ? 32'h1000 + 32'($urandom_range(0, 200))
                                       : 32'hFFFFFFF8 + 32'($urandom_range(0, 15));
            v   = $urandom; rd = 5'($urandom);
            n   = nbytes(f3);
            gap = $urandom_range(0, 2);
            mis = ref_misaligned(a, f3);
            if (!mis && $urandom_range(0, 2) == 0) begin r_at = 1; r_len = $urandom_range(1, 3); end
            else begin r_at = 0; r_len = 0; end
            exp_rv = ref_load(a, f3);
            exp_st = mis ? 1 : 1 + n + (ld ? 1 : 0) + gap * n + r_len;
            drive_op(ld ? LOAD : STORE, f3, a, v, 32'h0, rd, 1'b1, gap, r_at, r_len, st, f, rv, ra, merr, to);
            if (!ld && !mis) for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = v[8 * i +: 8];
            checks++; if (to || st !== exp_st) begin errors++; $display("FAIL rnd%0d_stall got %0d exp %0d", k, st, exp_st); end
            checks++; if (f !== (ld && !mis)) begin errors++; $display("FAIL rnd%0d_fwd got %b exp %b", k, f, ld && !mis); end
            if (ld && !mis) begin
                checks++; if (rv !== exp_rv || ra !== rd) begin
                    errors++; $display("FAIL rnd%0d_rd_val got %h/%0d exp %h/%0d", k, rv, ra, exp_rv, rd); end
            end
            checks++; if (merr !== (mis ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_misalign got %0d exp %0d", k, merr, mis ? 1 : 0); end
            checks++; if (log_q.size() !== (mis ? 0 : n)) begin
                errors++; $display("FAIL rnd%0d_xfers got %0d exp %0d", k, log_q.size(), mis ? 0 : n); end
            else for (int i = 0; i < log_q.size(); i++) begin
                checks++;
                if (log_q[i].a !== a + 32'(i) || log_q[i].we !== !ld || (!ld && log_q[i].d !== v[8 * i +: 8])) begin
                    errors++; $display("FAIL rnd%0d_xfer%0d got %b %h %h exp %b %h %h", k, i,
                                       log_q[i].we, log_q[i].a, log_q[i].d, !ld, a + 32'(i), v[8 * i +: 8]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; mem_gnt = 1'b0; forward = 1'b0; rd_addr = '0; rd_val = '0;
        ins_type = ALU; ins_details = '0; mem_addr = '0; mem_val = '0; mem_rdata = '0;
        test_reset();
        test_passthrough();
        test_lw();
        test_lb_lbu();
        test_sh_gap();
        test_rdy_pause();
        test_reset_mid();
        test_align();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
